home_sensor_conditioner: RTL
============================

// Module: home_sensor_conditioner
// PURPOSE
//  Upstream front end of the home automation controller. Synchronises and debounces the
//  four raw binary sensors (front door, rear door, window, fire alarm). Averages the
//  7-bit temperature samples with a moving average. Drives clean sfd/srd/sw/sfa/st into
//  the homeSystem controller.
// PARAMETERS
//  DEB_CYCLES     16  stable cycles needed before a debounced output changes (>=2)
//  AVG_LOG2       2   log2 of moving-average depth (default depth 4)
//  TEMP_W         7   temperature width, unsigned
//  TEMP_RESET     25  reset value of st and of every average-buffer entry
// PORTS
//  clk       in   1       system clock, rising edge
//  rst       in   1       synchronous, active-high reset
//  sfd_raw   in   1       raw front-door sensor, asynchronous
//  srd_raw   in   1       raw rear-door sensor, asynchronous
//  sw_raw    in   1       raw window sensor, asynchronous
//  sfa_raw   in   1       raw fire-alarm sensor, asynchronous
//  temp_in   in   TEMP_W  temperature sample
//  temp_vld  in   1       temp_in valid this cycle; sample is taken on this edge
//  fire_clr  in   1       [FIRE_LATCH_EN only] clear latched fire alarm
//  sfd,srd,sw,sfa out 1   debounced sensor levels to controller
//  st        out  TEMP_W  averaged temperature to controller
//  st_upd    out  1       one-cycle pulse: st updated this cycle
// BEHAVIOUR
//  Reset (rst=1 at an edge; overrides every other input):
//   sync flops, debounce counters, sfd/srd/sw/sfa, st_upd all 0;
//   buffer entries = TEMP_RESET; sum = TEMP_RESET<<AVG_LOG2; wr_ptr = 0; st = TEMP_RESET.
//  Per sensor: 2-flop synchroniser, then debounce FSM
//   STABLE: sync==out, counter held at 0. sync!=out -> counter=1, go to COUNT.
//   COUNT:  sync==out -> counter=0, back to STABLE (glitch rejected).
//           sync!=out and counter==DEB_CYCLES-1 -> out<=sync, counter=0, STABLE.
//           otherwise counter++.
//   Latency: a raw level held steady changes out on the (DEB_CYCLES+2)th rising edge
//   after it is first sampled. Shorter pulses never reach out.
//   Counter width $clog2(DEB_CYCLES). Counter saturates by construction and never wraps.
//  Temperature average (circular buffer, 2**AVG_LOG2 entries):
//   Edge with temp_vld=1: buf[wr_ptr]<=temp_in; sum<=sum+temp_in-buf[wr_ptr];
//    wr_ptr++ (wraps modulo depth).
//   Next edge: st<=sum>>AVG_LOG2 (truncating); st_upd=1 for that cycle only.
//    Total latency: 2 edges.
//   temp_vld may be high every cycle; each sample is accepted. st_upd then stays high.
//   sum width TEMP_W+AVG_LOG2, so it cannot overflow. st holds between updates.
//  rst mid-debounce or mid-average discards all partial state. There is no partial flush.
// CONFIGURATION
//  FIRE_LATCH_EN defined:
//   - sfa sets when the debounced fire level goes 1, and stays 1 afterwards.
//   - sfa clears only on an edge with fire_clr=1 and debounced fire level 0.
//   - fire_clr while the fire level is still 1 is ignored.
//   - The fire_clr port exists.
//  Undefined: sfa = debounced fire level; the fire_clr port is absent.
// STRUCTURE
//  Package home_pkg: TEMP_W_C, TEMP_RESET_C, sensor index enum
//   (SENS_FD, SENS_RD, SENS_W, SENS_FA), debounce state enum.
//  Sub-module sensor_debounce (synchroniser + FSM + counter, parameter DEB_CYCLES),
//   instantiated 4x. Averager inline.
// TESTING
//  1. Reset: rst=1 for 2 edges -> sfd=srd=sw=sfa=0, st=25, st_upd=0.
//  2. sw_raw=1 for 5 cycles then 0 -> sw stays 0. sw_raw=1 held -> sw=1 exactly on the
//     18th edge (DEB=16).
//  3. One temp_vld with temp_in=40 -> st=28 ((75+40)>>2) two edges later, st_upd one
//     cycle. Four total 40s -> st=40.
//  4. Wrap: back-to-back samples 10,20,30,40,50 -> final st=35. st_upd high 5 cycles.
//  5. rst=1 at counter=10 of srd debounce, raw kept 1 -> srd=0. Full 18 edges required
//     after rst drops.
//  6. FIRE_LATCH_EN: sfa_raw high 20 cycles, then low -> sfa stays 1. fire_clr while
//     raw high -> ignored. fire_clr after debounced low -> sfa=0 next edge.

Source files
------------

// File: rtl/home_sensor_conditioner_pkg.sv
// Shared types and defaults for the home sensor conditioner.
package home_pkg;
  localparam int TEMP_W_C     = 7;
  localparam int TEMP_RESET_C = 25;

  typedef enum logic [1:0] {
    SENS_FD = 2'd0,
    SENS_RD = 2'd1,
    SENS_W  = 2'd2,
    SENS_FA = 2'd3
  } sens_idx_e;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_COUNT  = 1'b1
  } deb_state_e;
endpackage

// File: rtl/home_sensor_conditioner_debounce.sv
// One binary sensor: 2-flop synchroniser followed by a counting debounce FSM.
module sensor_debounce
  import home_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_s1, r_s2, r_out;
  logic [CW-1:0] r_cnt;
  deb_state_e    r_state;

  deb_state_e    w_nstate;
  logic [CW-1:0] w_ncnt;
  logic          w_nout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_out   <= 1'b0;
      r_cnt   <= '0;
      r_state <= DB_STABLE;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_out   <= w_nout;
      r_cnt   <= w_ncnt;
      r_state <= w_nstate;
    end
  end

  // Counter tops out at DEB_CYCLES-1, where the output flips and it returns to 0.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nout   = r_out;
    case (r_state)
      DB_STABLE: begin
        if (r_s2 != r_out) begin
          w_ncnt   = CW'(1);
          w_nstate = DB_COUNT;
        end else begin
          w_ncnt   = '0;
        end
      end
      DB_COUNT: begin
        if (r_s2 == r_out) begin
          w_ncnt   = '0;
          w_nstate = DB_STABLE;
        end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          w_nout   = r_s2;
          w_ncnt   = '0;
          w_nstate = DB_STABLE;
        end else begin
          w_ncnt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_ncnt   = '0;
        w_nstate = DB_STABLE;
      end
    endcase
  end

  assign deb = r_out;
endmodule

// File: rtl/home_sensor_conditioner.sv
// Sensor front end: four debounced binary sensors plus moving-average temperature.
// Optional FIRE_LATCH_EN makes sfa sticky until cleared with fire_clr.
module home_sensor_conditioner
  import home_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int AVG_LOG2   = 2,
  parameter int TEMP_W     = TEMP_W_C,
  parameter int TEMP_RESET = TEMP_RESET_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sfd_raw,
  input  logic              srd_raw,
  input  logic              sw_raw,
  input  logic              sfa_raw,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_vld,
`ifdef FIRE_LATCH_EN
  input  logic              fire_clr,
`endif
  output logic              sfd,
  output logic              srd,
  output logic              sw,
  output logic              sfa,
  output logic [TEMP_W-1:0] st,
  output logic              st_upd
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;

  logic [3:0] w_raw, w_deb;

  assign w_raw[SENS_FD] = sfd_raw;
  assign w_raw[SENS_RD] = srd_raw;
  assign w_raw[SENS_W]  = sw_raw;
  assign w_raw[SENS_FA] = sfa_raw;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (w_raw[g]),
      .deb (w_deb[g])
    );
  end

  assign sfd = w_deb[SENS_FD];
  assign srd = w_deb[SENS_RD];
  assign sw  = w_deb[SENS_W];

`ifdef FIRE_LATCH_EN
  logic r_fire_lat;

  // Clearing is only honoured once the debounced fire level has dropped.
  always_ff @(posedge clk) begin
    if (rst)                  r_fire_lat <= 1'b0;
    else if (w_deb[SENS_FA])  r_fire_lat <= 1'b1;
    else if (fire_clr)        r_fire_lat <= 1'b0;
  end

  assign sfa = r_fire_lat | w_deb[SENS_FA];
`else
  assign sfa = w_deb[SENS_FA];
`endif

  logic [TEMP_W-1:0]   r_buf [DEPTH];
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [SUM_W-1:0]    r_sum;
  logic                r_pend, r_st_upd;
  logic [TEMP_W-1:0]   r_st;
  logic [TEMP_W-1:0]   w_avg;

  assign w_avg = TEMP_W'(r_sum >> AVG_LOG2);

  // Running sum replaces the oldest entry; st follows one edge after the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= TEMP_W'(TEMP_RESET);
      r_sum    <= SUM_W'(TEMP_RESET * DEPTH);
      r_wr_ptr <= '0;
      r_pend   <= 1'b0;
      r_st_upd <= 1'b0;
      r_st     <= TEMP_W'(TEMP_RESET);
    end else begin
      r_pend   <= temp_vld;
      r_st_upd <= r_pend;
      if (r_pend) r_st <= w_avg;
      if (temp_vld) begin
        r_buf[r_wr_ptr] <= temp_in;
        r_sum           <= r_sum + SUM_W'(temp_in) - SUM_W'(r_buf[r_wr_ptr]);
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
    end
  end

  assign st     = r_st;
  assign st_upd = r_st_upd;
endmodule
